gpu_fb_writer: RTL and testbench

//  Parametrised framebuffer SRAM write engine for the GPU; successor to the fixed two-buffer writer.

---
 rtl/gpu_fb_pkg.sv | 24 ++
 rtl/gpu_fb_sweep_counter.sv | 35 +++
 rtl/gpu_fb_writer.sv | 152 +++++++++++++++
 tb/tb_gpu_fb_writer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/gpu_fb_pkg.sv
// Shared types and constants for the framebuffer SRAM write engine.
package gpu_fb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StWrite,
      StClear,
      StSwap
   } fb_state_t;

   // SRAM pin levels when no write is in progress
   localparam logic CE0_IDLE    = 1'b1;
   localparam logic CE1_IDLE    = 1'b0;
   localparam logic STROBE_IDLE = 1'b1;
   localparam logic ZZ_LEVEL    = 1'b0;
   localparam logic SEM_LEVEL   = 1'b1;

   localparam int unsigned DEF_CHANNEL_BITS = 8;
   localparam int unsigned DEF_WIDTH_BITS   = 9;
   localparam int unsigned DEF_HEIGHT_BITS  = 9;
   localparam int unsigned DEF_NUM_BUFFERS  = 2;
   localparam int unsigned DEF_WAIT_STATES  = 1;

endpackage

// File: rtl/gpu_fb_sweep_counter.sv
// Clear-sweep address counter with a per-address wait-state counter.
module gpu_fb_sweep_counter #(
   parameter int unsigned ADDR_BITS   = 18,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 advance,
   output logic [ADDR_BITS-1:0] addr,
   output logic                 wait_done,
   output logic                 last
);

   logic [2:0] wait_cnt;

   assign wait_done = (wait_cnt == 3'(WAIT_STATES));
   assign last      = wait_done & (&addr);

   // Hold each address for WAIT_STATES+1 cycles, then step to the next
   always_ff @(posedge clk) begin
      if (rst || start) begin
         addr     <= '0;
         wait_cnt <= '0;
      end else if (advance) begin
         if (wait_done) begin
            wait_cnt <= '0;
            addr     <= addr + 1'b1;
         end else begin
            wait_cnt <= wait_cnt + 3'd1;
         end
      end
   end

endmodule

// File: rtl/gpu_fb_writer.sv
// Framebuffer SRAM write engine: pixel writes, clear sweep and N-way buffer rotation.
module gpu_fb_writer
   import gpu_fb_pkg::*;
#(
   parameter int unsigned CHANNEL_BITS = DEF_CHANNEL_BITS,
   parameter int unsigned WIDTH_BITS   = DEF_WIDTH_BITS,
   parameter int unsigned HEIGHT_BITS  = DEF_HEIGHT_BITS,
   parameter int unsigned NUM_BUFFERS  = DEF_NUM_BUFFERS,
   parameter int unsigned WAIT_STATES  = DEF_WAIT_STATES,
   localparam int unsigned BUF_BITS    = $clog2(NUM_BUFFERS),
   localparam int unsigned PIX_BITS    = WIDTH_BITS + HEIGHT_BITS,
   localparam int unsigned RGB_BITS    = 3 * CHANNEL_BITS
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         px_valid_i,
   output logic                         px_ready_o,
   input  logic [PIX_BITS-1:0]          px_addr_i,
   input  logic [RGB_BITS-1:0]          px_rgb_i,
   input  logic                         swap_req_i,
   input  logic                         clear_req_i,
   input  logic [RGB_BITS-1:0]          clear_rgb_i,
   output logic                         CE0_o,
   output logic                         CE1_o,
   output logic                         R_W_o,
   output logic                         OE_o,
   output logic                         UB_o,
   output logic                         LB_o,
   output logic                         ZZ_o,
   output logic                         SEM_o,
   output logic [BUF_BITS+PIX_BITS-1:0] adddataout_o,
   output logic [RGB_BITS-1:0]          rgbdataout_o,
   output logic [BUF_BITS-1:0]          buffer_select_o,
   output logic [BUF_BITS-1:0]          display_buffer_o,
   output logic                         busy_o,
   output logic                         frame_done_o
);

   fb_state_t           state;
   logic                strobe;
   logic                pend_clear;
   logic                pend_swap;
   logic [RGB_BITS-1:0] pend_rgb;
   logic                idle;
   logic                take_clear;
   logic                take_swap;
   logic                take_px;
   logic [PIX_BITS-1:0] sweep_addr;
   logic                sweep_start;
   logic                sweep_advance;
   logic                wait_done;
   logic                sweep_last;

   // Incoming request pulses count as pending in the same cycle, so a pixel
   // presented alongside a clear/swap is never accepted ahead of it.
   assign idle       = (state == StIdle);
   assign take_clear = idle & (pend_clear | clear_req_i);
   assign take_swap  = idle & ~take_clear & (pend_swap | swap_req_i);
   assign px_ready_o = ~rst & idle & ~pend_clear & ~pend_swap & ~clear_req_i & ~swap_req_i;
   assign take_px    = px_valid_i & px_ready_o;
   assign busy_o     = ~idle | pend_clear | pend_swap;

   assign sweep_start   = (state == StIdle) | (state == StSwap);
   assign sweep_advance = (state == StWrite) | (state == StClear);

   // All write strobes move together from one register
   assign CE0_o = strobe ? ~CE0_IDLE : CE0_IDLE;
   assign CE1_o = strobe ? ~CE1_IDLE : CE1_IDLE;
   assign R_W_o = strobe ? ~STROBE_IDLE : STROBE_IDLE;
   assign UB_o  = strobe ? ~STROBE_IDLE : STROBE_IDLE;
   assign LB_o  = strobe ? ~STROBE_IDLE : STROBE_IDLE;
   assign OE_o  = STROBE_IDLE;
   assign ZZ_o  = ZZ_LEVEL;
   assign SEM_o = SEM_LEVEL;

   gpu_fb_sweep_counter #(
      .ADDR_BITS   (PIX_BITS),
      .WAIT_STATES (WAIT_STATES)
   ) u_sweep (
      .clk       (clk),
      .rst       (rst),
      .start     (sweep_start),
      .advance   (sweep_advance),
      .addr      (sweep_addr),
      .wait_done (wait_done),
      .last      (sweep_last)
   );

   // Request latching, SRAM write sequencing and buffer rotation
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= StIdle;
         strobe           <= 1'b0;
         pend_clear       <= 1'b0;
         pend_swap        <= 1'b0;
         pend_rgb         <= '0;
         adddataout_o     <= '0;
         rgbdataout_o     <= '0;
         buffer_select_o  <= '0;
         display_buffer_o <= BUF_BITS'(NUM_BUFFERS - 1);
         frame_done_o     <= 1'b0;
      end else begin
         pend_clear   <= (pend_clear | clear_req_i) & ~take_clear;
         pend_swap    <= (pend_swap | swap_req_i) & ~take_swap;
         frame_done_o <= 1'b0;
         if (clear_req_i) begin
            pend_rgb <= clear_rgb_i;
         end
         unique case (state)
            StIdle: begin
               if (take_clear) begin
                  state        <= StClear;
                  strobe       <= 1'b1;
                  adddataout_o <= {buffer_select_o, {PIX_BITS{1'b0}}};
                  rgbdataout_o <= clear_req_i ? clear_rgb_i : pend_rgb;
               end else if (take_swap) begin
                  state <= StSwap;
               end else if (take_px) begin
                  state        <= StWrite;
                  strobe       <= 1'b1;
                  adddataout_o <= {buffer_select_o, px_addr_i};
                  rgbdataout_o <= px_rgb_i;
               end
            end
            StWrite: begin
               if (wait_done) begin
                  state  <= StIdle;
                  strobe <= 1'b0;
               end
            end
            StClear: begin
               if (sweep_last) begin
                  state  <= StIdle;
                  strobe <= 1'b0;
               end else if (wait_done) begin
                  // Strobe stays asserted; only the address moves on
                  adddataout_o[PIX_BITS-1:0] <= sweep_addr + 1'b1;
               end
            end
            StSwap: begin
               display_buffer_o <= buffer_select_o;
               buffer_select_o  <= (buffer_select_o == BUF_BITS'(NUM_BUFFERS - 1)) ?
                                   '0 : buffer_select_o + 1'b1;
               frame_done_o     <= 1'b1;
               state            <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_gpu_fb_writer.sv
// Directed bench for gpu_fb_writer: a default-sized instance and a small 4x4, 3-buffer one.
module tb_gpu_fb_writer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Default instance: 9x9 address, 2 buffers, 1 wait state
   logic        d_px_valid, d_px_ready, d_swap_req, d_clear_req;
   logic [17:0] d_px_addr;
   logic [23:0] d_px_rgb, d_clear_rgb, d_rgb;
   logic        d_ce0, d_ce1, d_r_w, d_oe, d_ub, d_lb, d_zz, d_sem, d_busy, d_fdone;
   logic [18:0] d_addr;
   logic [0:0]  d_bsel, d_disp;
   logic [7:0]  d_pins;

   // Small instance: 2x2 address bits, 3 buffers, no wait states
   logic        s_px_valid, s_px_ready, s_swap_req, s_clear_req;
   logic [3:0]  s_px_addr;
   logic [23:0] s_px_rgb, s_clear_rgb, s_rgb;
   logic        s_ce0, s_ce1, s_r_w, s_oe, s_ub, s_lb, s_zz, s_sem, s_busy, s_fdone;
   logic [5:0]  s_addr;
   logic [1:0]  s_bsel, s_disp;
   logic [7:0]  s_pins;

   assign d_pins = {d_ce0, d_ce1, d_r_w, d_oe, d_ub, d_lb, d_zz, d_sem};
   assign s_pins = {s_ce0, s_ce1, s_r_w, s_oe, s_ub, s_lb, s_zz, s_sem};

   localparam logic [7:0] PINS_IDLE  = 8'hBD;
   localparam logic [7:0] PINS_WRITE = 8'h51;

   gpu_fb_writer u_def (
      .clk(clk), .rst(rst),
      .px_valid_i(d_px_valid), .px_ready_o(d_px_ready), .px_addr_i(d_px_addr),
      .px_rgb_i(d_px_rgb), .swap_req_i(d_swap_req), .clear_req_i(d_clear_req),
      .clear_rgb_i(d_clear_rgb), .CE0_o(d_ce0), .CE1_o(d_ce1), .R_W_o(d_r_w), .OE_o(d_oe),
      .UB_o(d_ub), .LB_o(d_lb), .ZZ_o(d_zz), .SEM_o(d_sem), .adddataout_o(d_addr),
      .rgbdataout_o(d_rgb), .buffer_select_o(d_bsel), .display_buffer_o(d_disp),
      .busy_o(d_busy), .frame_done_o(d_fdone)
   );

   gpu_fb_writer #(
      .CHANNEL_BITS(8), .WIDTH_BITS(2), .HEIGHT_BITS(2), .NUM_BUFFERS(3), .WAIT_STATES(0)
   ) u_small (
      .clk(clk), .rst(rst),
      .px_valid_i(s_px_valid), .px_ready_o(s_px_ready), .px_addr_i(s_px_addr),
      .px_rgb_i(s_px_rgb), .swap_req_i(s_swap_req), .clear_req_i(s_clear_req),
      .clear_rgb_i(s_clear_rgb), .CE0_o(s_ce0), .CE1_o(s_ce1), .R_W_o(s_r_w), .OE_o(s_oe),
      .UB_o(s_ub), .LB_o(s_lb), .ZZ_o(s_zz), .SEM_o(s_sem), .adddataout_o(s_addr),
      .rgbdataout_o(s_rgb), .buffer_select_o(s_bsel), .display_buffer_o(s_disp),
      .busy_o(s_busy), .frame_done_o(s_fdone)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   logic [1:0]  exp_sel  [3] = '{2'd1, 2'd2, 2'd0};
   logic [1:0]  exp_disp [3] = '{2'd0, 2'd1, 2'd2};
   logic [5:0]  wr_addr [$];
   logic [23:0] wr_rgb  [$];
   int          wr_cyc  [$];
   int          lows;
   int          pulses;
   int          fdone_at;
   logic        take;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      d_px_valid = 1'b0; d_px_addr = '0; d_px_rgb = '0;
      d_swap_req = 1'b0; d_clear_req = 1'b0; d_clear_rgb = '0;
      s_px_valid = 1'b0; s_px_addr = '0; s_px_rgb = '0;
      s_swap_req = 1'b0; s_clear_req = 1'b0; s_clear_rgb = '0;

      // 1: reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset pins", d_pins, PINS_IDLE);
      check("reset addr", d_addr, 0);
      check("reset rgb", d_rgb, 0);
      check("reset buffer_select", d_bsel, 0);
      check("reset display nb2", d_disp, 1);
      check("reset display nb3", s_disp, 2);
      check("reset ready", d_px_ready, 0);
      check("reset frame_done", d_fdone, 0);
      check("reset busy", d_busy, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("ready after reset", d_px_ready, 1);

      // 2: single pixel with one wait state
      @(posedge clk); #1;
      d_px_valid = 1'b1; d_px_addr = 18'h10203; d_px_rgb = 24'hFF8000;
      @(posedge clk); #1 d_px_valid = 1'b0;
      lows = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (d_r_w == 1'b0) lows++;
         if (i == 0) begin
            check("pixel pins", d_pins, PINS_WRITE);
            check("pixel addr", d_addr, 32'h10203);
            check("pixel rgb", d_rgb, 32'hFF8000);
            check("pixel ready low", d_px_ready, 0);
            check("pixel busy", d_busy, 1);
         end
         if (i == 1) check("pixel addr stable", d_addr, 32'h10203);
         if (i == 1) check("pixel ready still low", d_px_ready, 0);
         if (i == 2) check("pixel ready again", d_px_ready, 1);
         if (i == 2) check("pixel pins released", d_pins, PINS_IDLE);
      end
      check("pixel strobe cycles", lows, 2);

      // 3: clear sweep of 16 addresses, no wait states
      @(posedge clk); #1;
      s_clear_rgb = 24'h123456; s_clear_req = 1'b1;
      @(posedge clk); #1 s_clear_req = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("clear strobe", s_pins, PINS_WRITE);
         check("clear addr", s_addr, i);
         check("clear rgb", s_rgb, 32'h123456);
         check("clear busy", s_busy, 1);
      end
      @(negedge clk);
      check("clear end pins", s_pins, PINS_IDLE);
      check("clear end busy", s_busy, 0);

      // 4: rotation through three buffers
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1 s_swap_req = 1'b1;
         @(posedge clk); #1 s_swap_req = 1'b0;
         @(negedge clk);
         if (s_fdone) pulses++;
         check("swap busy", s_busy, 1);
         check("swap pins idle", s_pins, PINS_IDLE);
         @(negedge clk);
         if (s_fdone) pulses++;
         check("swap buffer_select", s_bsel, exp_sel[k]);
         check("swap display", s_disp, exp_disp[k]);
         check("swap frame_done", s_fdone, 1);
         @(negedge clk);
         if (s_fdone) pulses++;
      end
      check("frame_done pulses", pulses, 3);

      // 5: clear + swap + pixel in the same cycle
      @(posedge clk); #1;
      s_clear_req = 1'b1; s_clear_rgb = 24'hABCDEF; s_swap_req = 1'b1;
      s_px_valid = 1'b1; s_px_addr = 4'h5; s_px_rgb = 24'h00FF00;
      #1 check("simul ready blocked", s_px_ready, 0);
      fdone_at = -1;
      @(posedge clk); #1 s_clear_req = 1'b0; s_swap_req = 1'b0;
      for (int c = 1; c < 60; c++) begin
         @(negedge clk);
         if (s_r_w == 1'b0) begin
            wr_addr.push_back(s_addr);
            wr_rgb.push_back(s_rgb);
            wr_cyc.push_back(c);
         end
         if (s_fdone) fdone_at = c;
         take = s_px_valid & s_px_ready;
         @(posedge clk); #1;
         if (take) s_px_valid = 1'b0;
      end
      check("simul pixel accepted", s_px_valid, 0);
      check("simul write count", wr_addr.size(), 17);
      if (wr_addr.size() == 17) begin
         for (int i = 0; i < 16; i++) begin
            check("simul clear addr", wr_addr[i], i);
            check("simul clear rgb", wr_rgb[i], 32'hABCDEF);
         end
         check("simul pixel addr", wr_addr[16], 32'h15);
         check("simul pixel rgb", wr_rgb[16], 32'h00FF00);
         check("simul swap order", (fdone_at > wr_cyc[15]) && (fdone_at < wr_cyc[16]), 1);
      end
      check("simul buffer_select", s_bsel, 1);

      // 6: reset in the middle of a clear
      s_clear_rgb = 24'h0F0F0F; s_clear_req = 1'b1;
      @(posedge clk); #1 s_clear_req = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("abort clear active", s_pins, PINS_WRITE);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("abort pins", s_pins, PINS_IDLE);
      check("abort buffer_select", s_bsel, 0);
      check("abort display", s_disp, 2);
      check("abort addr", s_addr, 0);
      check("abort busy", s_busy, 0);
      lows = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (s_r_w == 1'b0) lows++;
      end
      check("abort no further writes", lows, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
